pkt_buf_ctrl: RTL and testbench
===============================

# pkt_buf_ctrl

Parametrised packet buffer controller: stores FAST-format packets (2-bit head/body/tail flag in the top data bits) into an internal dual-port RAM at an externally allocated base address, and replays a stored packet from a requested address and beat count. Sits between the input packet path and the output cache, with the address manager supplying write and read addresses. Adds over the previous generation: configurable width/depth/latency, an explicit read length, a read-request ready handshake, write-completion reporting, and optional over-length protection.

## Interface
- DATA_W, 134, beat width; bits [DATA_W-1:DATA_W-2] are flags: 01 head, 11 body, 10 tail
- ADDR_W, 11, RAM address width; depth 2^ADDR_W
- LEN_W, 6, beat-count width
- RD_LAT, 1, RAM read latency in cycles (1 or 2)
- MAX_BEATS, 32, max packet beats (used only with PKT_BUF_OVF_CHK_EN)

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_data  in  DATA_W  packet beat
- in_data_wr  in  1  beat strobe
- waddr  in  ADDR_W  base address for the packet whose head is present
- waddr_wr  in  1  waddr valid
- wr_done  out  1  one-cycle pulse: packet fully written
- wr_done_addr  out  ADDR_W  base address of completed packet
- wr_done_len  out  LEN_W  beats written
- wr_err  out  1  one-cycle pulse: beat/packet dropped or truncated
- raddr  in  ADDR_W  read start address
- rlen  in  LEN_W  beats to read
- raddr_wr  in  1  read request strobe
- raddr_ready  out  1  read request accepted when raddr_wr & raddr_ready
- out_data  out  DATA_W  replayed beat
- out_data_wr  out  1  out_data valid
- out_eop  out  1  asserted with the last beat of a read

## Operation
- Write FSM: W_IDLE, W_PKT, W_DROP.
  - W_IDLE: in_data_wr with flag 01 and waddr_wr: write beat at waddr, count=1, latch base, go W_PKT. Flag 01 without waddr_wr: wr_err, go W_DROP. Non-head beat: discard, wr_err, stay.
  - W_PKT: each in_data_wr writes at base+count (mod 2^ADDR_W), count++. Flag 10: wr_done, wr_done_addr=base, wr_done_len=count incl. tail, go W_IDLE. Flag 01 received: treated as error-terminated packet: wr_err, no wr_done, restart as new head per W_IDLE rules.
  - W_DROP: discard until flag 10, then W_IDLE.
- Read FSM: R_IDLE, R_ISSUE, R_DRAIN.
  - R_IDLE: raddr_ready=1. Accept with rlen>0: go R_ISSUE. rlen==0: accepted, no output, stay.
  - R_ISSUE: issue one RAM read per cycle at raddr, raddr+1, ... (mod 2^ADDR_W) for rlen cycles, then R_DRAIN.
  - R_DRAIN: wait for last beat output (out_eop), then R_IDLE.
- Beats replayed unmodified; no header parsing.
- Write and read ports independent; concurrent operation allowed. Same address written and read in one cycle: read returns old data.

## Timing
- Write: RAM write occurs cycle after the accepted in_data_wr beat. wr_done/wr_err asserted the cycle after the tail/offending beat.
- Read: request accepted at cycle T; first RAM read issued T+1; beat k (0-based) on out_data at T+2+RD_LAT+k; out_data_wr continuous for rlen cycles; out_eop with final beat.
- raddr_ready low from T+1 until the cycle after out_eop; minimum request spacing rlen+RD_LAT+2 cycles.
- Reset: all outputs 0 except raddr_ready=0 during rst, 1 first cycle after; both FSMs to idle; in-flight write abandoned without wr_done; in-flight read aborted, no further out_data_wr. RAM contents not cleared.
- Count arithmetic LEN_W bits; addresses wrap modulo 2^ADDR_W.

## Configuration
- PKT_BUF_OVF_CHK_EN defined: in W_PKT, beat number MAX_BEATS without flag 10 is written with flags forced to 10; wr_done (len=MAX_BEATS) and wr_err same cycle; go W_DROP to discard rest.
- Undefined: no length limit; count wraps modulo 2^LEN_W, wr_done_len reports wrapped value.

## Test plan
- 4-beat packet (01,11,11,10), waddr=0x100 -> RAM 0x100..0x103 written, wr_done with addr 0x100, len 4, one cycle after tail.
- Read raddr=0x100, rlen=4, RD_LAT=1 at T -> out_data_wr T+3..T+6, beats identical, out_eop at T+6, raddr_ready high again T+7.
- Packet at waddr=0x7FE, 4 beats -> writes 0x7FE,0x7FF,0x000,0x001; read rlen=4 from 0x7FE returns same order.
- Head without waddr_wr, 3 beats -> wr_err once, nothing written, no wr_done; next valid packet stored normally.
- With PKT_BUF_OVF_CHK_EN, MAX_BEATS=32, 40-beat packet -> 32 beats written, beat 32 flags=10, wr_done len 32 and wr_err together, beats 33-40 dropped.
- rst asserted mid-read (beat 2 of 8) -> out_data_wr 0 next cycle, raddr_ready 1 first cycle after rst release, new read served correctly.

Source files
------------

// File: rtl/pkt_buf_ctrl_if.sv
// pkt_buf_ctrl_if: bundles the write-beat, write-completion, read-request
// and replay signals of the packet buffer controller.
//
// Handshake semantics:
//   in_data_wr   - strobe, no back-pressure: every cycle it is high one beat
//                  is consumed; waddr is only looked at alongside a head beat.
//   raddr_wr / raddr_ready - a read request transfers on a cycle where both
//                  are high; raddr/rlen must be stable on that cycle.
//   out_data_wr  - valid with no ready: the consumer must take every beat;
//                  out_eop marks the final beat of a read.
//   wr_done / wr_err - single-cycle pulses, no acknowledge.
interface pkt_buf_ctrl_if #(
  parameter int DATA_W = 134,
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 6
);
  logic [DATA_W-1:0] in_data;
  logic              in_data_wr;
  logic [ADDR_W-1:0] waddr;
  logic              waddr_wr;
  logic              wr_done;
  logic [ADDR_W-1:0] wr_done_addr;
  logic [LEN_W-1:0]  wr_done_len;
  logic              wr_err;
  logic [ADDR_W-1:0] raddr;
  logic [LEN_W-1:0]  rlen;
  logic              raddr_wr;
  logic              raddr_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_data_wr;
  logic              out_eop;

  modport master (
    output in_data, in_data_wr, waddr, waddr_wr, raddr, rlen, raddr_wr,
    input  wr_done, wr_done_addr, wr_done_len, wr_err, raddr_ready,
           out_data, out_data_wr, out_eop
  );

  modport slave (
    input  in_data, in_data_wr, waddr, waddr_wr, raddr, rlen, raddr_wr,
    output wr_done, wr_done_addr, wr_done_len, wr_err, raddr_ready,
           out_data, out_data_wr, out_eop
  );
endinterface

// File: rtl/pkt_buf_ctrl.sv
// pkt_buf_ctrl: stores head/body/tail flagged packets into an internal
// dual-port RAM at an externally supplied base address and replays a stored
// packet from a requested address and beat count.
// Optional feature macro: PKT_BUF_OVF_CHK_EN -- when defined, a packet that
// reaches MAX_BEATS beats without a tail is closed with a forced tail flag
// and the remainder is dropped.
module pkt_buf_ctrl #(
  parameter int DATA_W    = 134,
  parameter int ADDR_W    = 11,
  parameter int LEN_W     = 6,
  parameter int RD_LAT    = 1,
  parameter int MAX_BEATS = 32
) (
  input  logic         clk,
  input  logic         rst,
  pkt_buf_ctrl_if.slave bus,
  output logic [1:0]   dbg_w_state,
  output logic [1:0]   dbg_r_state
);

  localparam logic [1:0] FLAG_HEAD = 2'b01;
  localparam logic [1:0] FLAG_TAIL = 2'b10;

`ifdef PKT_BUF_OVF_CHK_EN
  localparam bit OVF_CHK = 1'b1;
`else
  localparam bit OVF_CHK = 1'b0;
`endif
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BEATS);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_PKT  = 2'd1,
    W_DROP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_DRAIN = 2'd2
  } r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  // ---------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------
  logic [1:0]        in_flag;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  cnt_nx;
  logic [ADDR_W-1:0] wr_ptr;
  logic              ovf_hit;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_wa;
  logic [DATA_W-1:0] ram_wd;

  assign in_flag = bus.in_data[DATA_W-1 -: 2];
  assign cnt_nx  = cnt_q + LEN_W'(1);
  assign wr_ptr  = base_q + ADDR_W'(cnt_q);
  // Beat number MAX_BEATS is being accepted and it is not a tail.
  assign ovf_hit = OVF_CHK && (cnt_nx == MAX_LEN);

  // Write FSM: accepts beats, stages the RAM write one cycle later and
  // raises the completion / error pulses the cycle after the deciding beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state          <= W_IDLE;
      base_q           <= '0;
      cnt_q            <= '0;
      ram_we           <= 1'b0;
      ram_wa           <= '0;
      ram_wd           <= '0;
      bus.wr_done      <= 1'b0;
      bus.wr_done_addr <= '0;
      bus.wr_done_len  <= '0;
      bus.wr_err       <= 1'b0;
    end else begin
      ram_we      <= 1'b0;
      bus.wr_done <= 1'b0;
      bus.wr_err  <= 1'b0;
      if (bus.in_data_wr) begin
        case (w_state)
          W_IDLE, W_PKT: begin
            if (in_flag == FLAG_HEAD) begin
              // A head inside an open packet kills that packet silently
              // (no wr_done) and is then handled as a fresh head.
              if (w_state == W_PKT) bus.wr_err <= 1'b1;
              if (bus.waddr_wr) begin
                ram_we  <= 1'b1;
                ram_wa  <= bus.waddr;
                ram_wd  <= bus.in_data;
                base_q  <= bus.waddr;
                cnt_q   <= LEN_W'(1);
                w_state <= W_PKT;
              end else begin
                bus.wr_err <= 1'b1;
                w_state    <= W_DROP;
              end
            end else if (w_state == W_IDLE) begin
              // Body or tail with no packet open: nothing to attach it to.
              bus.wr_err <= 1'b1;
            end else begin
              ram_we <= 1'b1;
              ram_wa <= wr_ptr;
              ram_wd <= bus.in_data;
              cnt_q  <= cnt_nx;
              if (in_flag == FLAG_TAIL) begin
                bus.wr_done      <= 1'b1;
                bus.wr_done_addr <= base_q;
                bus.wr_done_len  <= cnt_nx;
                w_state          <= W_IDLE;
              end else if (ovf_hit) begin
                ram_wd           <= {FLAG_TAIL, bus.in_data[DATA_W-3:0]};
                bus.wr_done      <= 1'b1;
                bus.wr_done_addr <= base_q;
                bus.wr_done_len  <= cnt_nx;
                bus.wr_err       <= 1'b1;
                w_state          <= W_DROP;
              end
            end
          end
          W_DROP: begin
            if (in_flag == FLAG_TAIL) w_state <= W_IDLE;
          end
          default: w_state <= W_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_ptr;
  logic [LEN_W-1:0]  rd_left;
  logic              rd_en;
  logic              rd_last;

  assign rd_en   = (r_state == R_ISSUE);
  assign rd_last = (rd_left == LEN_W'(1));

  // raddr_ready is decoded from the idle state and gated by rst so that it is
  // low while reset is held and high on the very first cycle after release.
  assign bus.raddr_ready = (r_state == R_IDLE) && !rst;

  // Read FSM: accepts a request, issues one RAM read per cycle, then waits
  // for the final beat to leave the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      rd_ptr  <= '0;
      rd_left <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          // A zero-length request is accepted and simply produces nothing.
          if (bus.raddr_wr && (bus.rlen != '0)) begin
            rd_ptr  <= bus.raddr;
            rd_left <= bus.rlen;
            r_state <= R_ISSUE;
          end
        end
        R_ISSUE: begin
          rd_ptr  <= rd_ptr + ADDR_W'(1);
          rd_left <= rd_left - LEN_W'(1);
          if (rd_last) r_state <= R_DRAIN;
        end
        R_DRAIN: begin
          if (bus.out_eop) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Storage: simple dual-port RAM, read-before-write on an address clash
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram_q;

  // RAM array: contents survive reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_wd;
    if (rd_en)  ram_q <= mem[rd_ptr];
  end

  logic v1;
  logic l1;

  // Tracks which RAM output cycles carry a beat and which one is the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      v1 <= rd_en;
      l1 <= rd_en && rd_last;
    end
  end

  logic [DATA_W-1:0] pipe_q;
  logic              pipe_v;
  logic              pipe_l;

  generate
    if (RD_LAT >= 2) begin : g_lat2
      logic [DATA_W-1:0] q2;
      logic              v2;
      logic              l2;

      // Extra register stage for a two-cycle RAM read latency.
      always_ff @(posedge clk) begin
        if (rst) begin
          q2 <= '0;
          v2 <= 1'b0;
          l2 <= 1'b0;
        end else begin
          q2 <= ram_q;
          v2 <= v1;
          l2 <= l1;
        end
      end

      assign pipe_q = q2;
      assign pipe_v = v2;
      assign pipe_l = l2;
    end else begin : g_lat1
      assign pipe_q = ram_q;
      assign pipe_v = v1;
      assign pipe_l = l1;
    end
  endgenerate

  // Output register: replays beats unmodified, marks the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_data    <= '0;
      bus.out_data_wr <= 1'b0;
      bus.out_eop     <= 1'b0;
    end else begin
      bus.out_data_wr <= pipe_v;
      bus.out_eop     <= pipe_v && pipe_l;
      if (pipe_v) bus.out_data <= pipe_q;
    end
  end

  assign dbg_w_state = w_state;
  assign dbg_r_state = r_state;

endmodule

// File: tb/tb_pkt_buf_ctrl.sv
// tb_pkt_buf_ctrl: directed and randomized checks of pkt_buf_ctrl against a
// packet-level reference model (array memory + expected-beat queue).
module tb_pkt_buf_ctrl;

  localparam int DATA_W    = 134;
  localparam int ADDR_W    = 11;
  localparam int LEN_W     = 6;
  localparam int RD_LAT    = 1;
  localparam int MAX_BEATS = 32;

  localparam logic [1:0] F_HEAD = 2'b01;
  localparam logic [1:0] F_BODY = 2'b11;
  localparam logic [1:0] F_TAIL = 2'b10;

  logic clk;
  logic rst;
  logic [1:0] dbg_w_state;
  logic [1:0] dbg_r_state;

  pkt_buf_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  pkt_buf_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .RD_LAT(RD_LAT), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_w_state(dbg_w_state),
    .dbg_r_state(dbg_r_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: RAM image and expected read beats
  logic [DATA_W-1:0] mem_m [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_beat(input logic [1:0] flag);
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return {flag, r[DATA_W-3:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: one packet of n beats, back to back. give_waddr supplies the
  // base address with the head; prior_open means a packet is still open so
  // the head terminates it with an error; open_end leaves off the tail.
  task automatic send_pkt(input logic [ADDR_W-1:0] base, input int n,
                          input bit give_waddr, input bit prior_open,
                          input bit open_end);
    logic [1:0]        flag;
    logic [DATA_W-1:0] beat;
    logic [DATA_W-1:0] wbeat;
    bit                exp_done;
    bit                exp_err;
    bit                wr;
    int                exp_len;
    for (int i = 0; i < n; i++) begin
      if (i == 0) flag = F_HEAD;
      else if (i == n - 1 && !open_end) flag = F_TAIL;
      else flag = F_BODY;
      beat     = rand_beat(flag);
      wbeat    = beat;
      exp_done = 1'b0;
      exp_err  = (i == 0) && (prior_open || !give_waddr);
      wr       = 1'b0;
      exp_len  = 0;
      if (give_waddr) begin
`ifdef PKT_BUF_OVF_CHK_EN
        if (i < MAX_BEATS) begin
          wr = 1'b1;
          if (flag == F_TAIL) begin
            exp_done = 1'b1;
            exp_len  = i + 1;
          end else if (i == MAX_BEATS - 1) begin
            wbeat[DATA_W-1 -: 2] = F_TAIL;
            exp_done = 1'b1;
            exp_err  = 1'b1;
            exp_len  = MAX_BEATS;
          end
        end
`else
        wr = 1'b1;
        if (flag == F_TAIL) begin
          exp_done = 1'b1;
          exp_len  = (i + 1) % (1 << LEN_W);
        end
`endif
      end
      if (wr) mem_m[base + ADDR_W'(i % (1 << LEN_W))] = wbeat;
      bus.in_data    = beat;
      bus.in_data_wr = 1'b1;
      bus.waddr      = base;
      bus.waddr_wr   = (i == 0) && give_waddr;
      tick();
      chk("wr_err", DATA_W'(bus.wr_err), DATA_W'(exp_err));
      chk("wr_done", DATA_W'(bus.wr_done), DATA_W'(exp_done));
      if (exp_done) begin
        chk("wr_done_addr", DATA_W'(bus.wr_done_addr), DATA_W'(base));
        chk("wr_done_len", DATA_W'(bus.wr_done_len), DATA_W'(exp_len));
      end
    end
    bus.in_data_wr = 1'b0;
    bus.waddr_wr   = 1'b0;
    tick();
    chk("wr_done_pulse", DATA_W'(bus.wr_done), '0);
    chk("wr_err_pulse", DATA_W'(bus.wr_err), '0);
  endtask

  // Driver + scoreboard for one read: checks every cycle from the request
  // up to the first cycle raddr_ready is back.
  task automatic do_read(input logic [ADDR_W-1:0] a, input int len);
    bit v;
    chk("rd_ready_pre", DATA_W'(bus.raddr_ready), DATA_W'(1));
    for (int k = 0; k < len; k++) exp_q.push_back(mem_m[a + ADDR_W'(k)]);
    bus.raddr    = a;
    bus.rlen     = LEN_W'(len);
    bus.raddr_wr = 1'b1;
    tick();
    bus.raddr_wr = 1'b0;
    for (int c = 1; c <= 2 + RD_LAT + len; c++) begin
      v = (c >= 2 + RD_LAT) && (c <= 1 + RD_LAT + len);
      chk("out_data_wr", DATA_W'(bus.out_data_wr), DATA_W'(v));
      chk("out_eop", DATA_W'(bus.out_eop), DATA_W'(c == 1 + RD_LAT + len));
      chk("raddr_ready", DATA_W'(bus.raddr_ready), DATA_W'(c == 2 + RD_LAT + len));
      if (v && exp_q.size() > 0) chk("out_data", bus.out_data, exp_q.pop_front());
      if (c < 2 + RD_LAT + len) tick();
    end
    chk("rd_q_empty", DATA_W'(exp_q.size()), '0);
    exp_q.delete();
  endtask

  // Directed sequence
  initial begin
    logic [ADDR_W-1:0] rb;
    int                rn;
    rst             = 1'b1;
    bus.in_data     = '0;
    bus.in_data_wr  = 1'b0;
    bus.waddr       = '0;
    bus.waddr_wr    = 1'b0;
    bus.raddr       = '0;
    bus.rlen        = '0;
    bus.raddr_wr    = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_wr_done", DATA_W'(bus.wr_done), '0);
    chk("rst_wr_err", DATA_W'(bus.wr_err), '0);
    chk("rst_out_wr", DATA_W'(bus.out_data_wr), '0);
    chk("rst_out_eop", DATA_W'(bus.out_eop), '0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_ready", DATA_W'(bus.raddr_ready), '0);
    rst = 1'b0;
    #1;
    chk("rel_ready", DATA_W'(bus.raddr_ready), DATA_W'(1));

    // Basic 4-beat packet and replay
    send_pkt(11'h100, 4, 1'b1, 1'b0, 1'b0);
    do_read(11'h100, 4);

    // Address wrap on write and read
    send_pkt(11'h7FE, 4, 1'b1, 1'b0, 1'b0);
    do_read(11'h7FE, 4);

    // Headless packet leaves earlier contents alone
    send_pkt(11'h200, 3, 1'b1, 1'b0, 1'b0);
    send_pkt(11'h200, 3, 1'b0, 1'b0, 1'b0);
    do_read(11'h200, 3);
    send_pkt(11'h208, 5, 1'b1, 1'b0, 1'b0);
    do_read(11'h208, 5);

    // Stray body beat with no open packet
    bus.in_data    = rand_beat(F_BODY);
    bus.in_data_wr = 1'b1;
    tick();
    bus.in_data_wr = 1'b0;
    chk("stray_err", DATA_W'(bus.wr_err), DATA_W'(1));
    chk("stray_done", DATA_W'(bus.wr_done), '0);
    tick();

    // Packet cut short by a new head
    send_pkt(11'h300, 3, 1'b1, 1'b0, 1'b1);
    send_pkt(11'h310, 4, 1'b1, 1'b1, 1'b0);
    do_read(11'h300, 3);
    do_read(11'h310, 4);

    // Zero-length read: accepted, produces nothing
    bus.raddr    = 11'h100;
    bus.rlen     = '0;
    bus.raddr_wr = 1'b1;
    tick();
    bus.raddr_wr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rlen0_ready", DATA_W'(bus.raddr_ready), DATA_W'(1));
      chk("rlen0_out_wr", DATA_W'(bus.out_data_wr), '0);
      tick();
    end

    // Randomized packets and partial replays
    for (int it = 0; it < 10; it++) begin
      rb = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      rn = $urandom_range(2, 12);
      send_pkt(rb, rn, 1'b1, 1'b0, 1'b0);
      do_read(rb + ADDR_W'($urandom_range(0, rn - 1)), $urandom_range(1, rn));
    end

    // Long packet: over-length cut, or beat count wrap without the check
`ifdef PKT_BUF_OVF_CHK_EN
    send_pkt(11'h500, 40, 1'b1, 1'b0, 1'b0);
    do_read(11'h500, 32);
`else
    send_pkt(11'h500, 65, 1'b1, 1'b0, 1'b0);
    do_read(11'h500, 4);
    do_read(11'h53C, 4);
`endif

    // Reset in the middle of an 8-beat read
    send_pkt(11'h600, 8, 1'b1, 1'b0, 1'b0);
    bus.raddr    = 11'h600;
    bus.rlen     = LEN_W'(8);
    bus.raddr_wr = 1'b1;
    tick();
    bus.raddr_wr = 1'b0;
    for (int c = 2; c <= 2 + RD_LAT + 2; c++) tick();
    chk("mid_out_wr", DATA_W'(bus.out_data_wr), DATA_W'(1));
    chk("mid_beat2", bus.out_data, mem_m[11'h602]);
    rst = 1'b1;
    tick();
    chk("abort_out_wr", DATA_W'(bus.out_data_wr), '0);
    chk("abort_eop", DATA_W'(bus.out_eop), '0);
    chk("abort_ready", DATA_W'(bus.raddr_ready), '0);
    rst = 1'b0;
    #1;
    chk("abort_rel_ready", DATA_W'(bus.raddr_ready), DATA_W'(1));
    tick();
    chk("abort_quiet", DATA_W'(bus.out_data_wr), '0);
    do_read(11'h600, 8);
    send_pkt(11'h640, 6, 1'b1, 1'b0, 1'b0);
    do_read(11'h640, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
